// File: rtl/isp_mode_sched.sv
// Frame-synchronous display-mode scheduler for the ISP top: commits mode requests
// (explicit or auto-cycled) only on in_vsync rising edges and blanks the output for whole frames after a switch.
module isp_mode_sched #(
    parameter int MODE_NUM     = 4,
    parameter int DEFAULT_MODE = 0,
    parameter int BLANK_FRAMES = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_vsync,
    input  logic [3:0] mode_req,
    input  logic       mode_req_valid,
    input  logic       auto_cycle_en,
    input  logic [7:0] cycle_frames,
    output logic [3:0] isp_disp_mode,
    output logic       blank_en,
    output logic       busy,
    output logic       req_err,
    output logic       mode_changed
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_BLANK = 2'd2;

    localparam logic [4:0] MODE_LIM   = 5'(MODE_NUM);
    localparam logic [3:0] MODE_MAX   = 4'(MODE_NUM - 1);
    localparam logic [3:0] MODE_RST   = 4'(DEFAULT_MODE);
    localparam logic [7:0] BLANK_LAST = 8'(BLANK_FRAMES);
    localparam logic       BLANK_ON   = (BLANK_FRAMES > 0);

    logic [1:0] state_q, state_d;
    logic [3:0] mode_q, mode_d;
    logic [3:0] pend_mode_q, pend_mode_d;
    logic       pend_q, pend_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic [7:0] blank_cnt_q, blank_cnt_d;
    logic       blank_q, blank_d;
    logic       req_err_q, req_err_d;
    logic       changed_q, changed_d;
    logic       vsync_q;

    logic       rise;
    logic       req_legal;
    logic       req_take;
    logic       auto_act;
    logic       commit_en;
    logic [3:0] commit_mode;
    logic [3:0] mode_next;
    logic [7:0] frame_inc;
    logic [7:0] blank_inc;

    assign rise      = in_vsync & ~vsync_q;
    assign req_legal = mode_req_valid && ({1'b0, mode_req} < MODE_LIM);
    // A request for the mode already on screen is a no-op only when nothing else is queued.
    assign req_take  = req_legal && !(state_q == ST_IDLE && !pend_q && mode_req == mode_q);
    assign auto_act  = auto_cycle_en && (cycle_frames != 8'd0) && (state_q == ST_IDLE) && !pend_q;
    assign mode_next = (mode_q >= MODE_MAX) ? 4'd0 : mode_q + 4'd1;
    assign frame_inc = frame_cnt_q + 8'd1;
    assign blank_inc = blank_cnt_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        pend_mode_d = pend_mode_q;
        pend_d      = pend_q;
        frame_cnt_d = auto_cycle_en ? frame_cnt_q : 8'd0;
        blank_cnt_d = blank_cnt_q;
        blank_d     = blank_q;
        req_err_d   = mode_req_valid && !req_legal;
        changed_d   = 1'b0;
        commit_en   = 1'b0;
        commit_mode = mode_q;

        case (state_q)
            ST_IDLE: begin
                if (req_take) begin
                    pend_d      = 1'b1;
                    pend_mode_d = mode_req;
                    state_d     = ST_WAIT;
                end else if (auto_act && rise) begin
                    if (frame_inc >= cycle_frames) begin
                        commit_en   = 1'b1;
                        commit_mode = mode_next;
                    end else begin
                        frame_cnt_d = frame_inc;
                    end
                end
            end
            ST_WAIT: begin
                // On a simultaneous rise the older pending mode commits; the new one stays queued.
                if (rise) begin
                    commit_en   = 1'b1;
                    commit_mode = pend_mode_q;
                    pend_d      = req_take;
                end
                if (req_take) begin
                    pend_d      = 1'b1;
                    pend_mode_d = mode_req;
                end
            end
            ST_BLANK: begin
                if (req_take) begin
                    pend_d      = 1'b1;
                    pend_mode_d = mode_req;
                end
                if (rise) begin
                    blank_cnt_d = blank_inc;
                    if (blank_inc >= BLANK_LAST) begin
                        blank_d = 1'b0;
                        state_d = pend_d ? ST_WAIT : ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (commit_en) begin
            mode_d      = commit_mode;
            changed_d   = 1'b1;
            frame_cnt_d = 8'd0;
            blank_cnt_d = 8'd0;
            blank_d     = BLANK_ON;
            state_d     = BLANK_ON ? ST_BLANK : (pend_d ? ST_WAIT : ST_IDLE);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_RST;
            pend_mode_q <= MODE_RST;
            pend_q      <= 1'b0;
            frame_cnt_q <= 8'd0;
            blank_cnt_q <= 8'd0;
            blank_q     <= 1'b0;
            req_err_q   <= 1'b0;
            changed_q   <= 1'b0;
            vsync_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            pend_mode_q <= pend_mode_d;
            pend_q      <= pend_d;
            frame_cnt_q <= frame_cnt_d;
            blank_cnt_q <= blank_cnt_d;
            blank_q     <= blank_d;
            req_err_q   <= req_err_d;
            changed_q   <= changed_d;
            vsync_q     <= in_vsync;
        end
    end

    assign isp_disp_mode = mode_q;
    assign blank_en      = blank_q;
    assign busy          = (state_q != ST_IDLE);
    assign req_err       = req_err_q;
    assign mode_changed  = changed_q;
endmodule

// File: tb/tb_isp_mode_sched.sv
// Directed bench for isp_mode_sched: three instances (BLANK_FRAMES = 1, 0, 2) share
// stimulus; each scenario checks the instance whose blanking setting it targets.
module tb_isp_mode_sched;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_vsync = 1'b0;
    logic [3:0] mode_req = 4'd0;
    logic       mode_req_valid = 1'b0;
    logic       auto_cycle_en = 1'b0;
    logic [7:0] cycle_frames = 8'd0;

    logic [3:0] mode1, mode0, mode2;
    logic       blank1, blank0, blank2;
    logic       busy1, busy0, busy2;
    logic       err1, err0, err2;
    logic       mc1, mc0, mc2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    isp_mode_sched #(.MODE_NUM(4), .DEFAULT_MODE(0), .BLANK_FRAMES(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .in_vsync(in_vsync), .mode_req(mode_req),
        .mode_req_valid(mode_req_valid), .auto_cycle_en(auto_cycle_en), .cycle_frames(cycle_frames),
        .isp_disp_mode(mode1), .blank_en(blank1), .busy(busy1), .req_err(err1), .mode_changed(mc1));

    isp_mode_sched #(.MODE_NUM(4), .DEFAULT_MODE(0), .BLANK_FRAMES(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .in_vsync(in_vsync), .mode_req(mode_req),
        .mode_req_valid(mode_req_valid), .auto_cycle_en(auto_cycle_en), .cycle_frames(cycle_frames),
        .isp_disp_mode(mode0), .blank_en(blank0), .busy(busy0), .req_err(err0), .mode_changed(mc0));

    isp_mode_sched #(.MODE_NUM(4), .DEFAULT_MODE(0), .BLANK_FRAMES(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .in_vsync(in_vsync), .mode_req(mode_req),
        .mode_req_valid(mode_req_valid), .auto_cycle_en(auto_cycle_en), .cycle_frames(cycle_frames),
        .isp_disp_mode(mode2), .blank_en(blank2), .busy(busy2), .req_err(err2), .mode_changed(mc2));

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        in_vsync = 1'b0;
        mode_req_valid = 1'b0;
        auto_cycle_en = 1'b0;
        cycle_frames = 8'd0;
        tick(3);
        reset_n = 1'b1;
        tick(2);
    endtask

    task automatic strobe(input logic [3:0] m);
        mode_req = m;
        mode_req_valid = 1'b1;
        tick(1);
        mode_req_valid = 1'b0;
    endtask

    task automatic vsync_edge();
        in_vsync = 1'b1;
        tick(1);
    endtask

    task automatic vsync_end();
        tick(2);
        in_vsync = 1'b0;
        tick(4);
    endtask

    initial begin
        logic [3:0] auto_seq [5];
        logic [3:0] prev;
        auto_seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};

        // Reset values and a single mid-frame request (BLANK_FRAMES=1).
        do_reset();
        check("rst_mode", 8'(mode1), 8'd0);
        check("rst_blank", 8'(blank1), 8'd0);
        check("rst_busy", 8'(busy1), 8'd0);
        check("rst_err", 8'(err1), 8'd0);
        check("rst_mc", 8'(mc1), 8'd0);
        vsync_edge(); vsync_end();
        tick(3);
        strobe(4'd2);
        check("req2_busy", 8'(busy1), 8'd1);
        check("req2_hold", 8'(mode1), 8'd0);
        tick(5);
        check("req2_hold_late", 8'(mode1), 8'd0);
        vsync_edge();
        check("req2_commit", 8'(mode1), 8'd2);
        check("req2_mc", 8'(mc1), 8'd1);
        check("req2_blank_on", 8'(blank1), 8'd1);
        tick(1);
        check("req2_mc_pulse", 8'(mc1), 8'd0);
        vsync_end();
        check("req2_blank_mid", 8'(blank1), 8'd1);
        vsync_edge();
        check("req2_blank_off", 8'(blank1), 8'd0);
        check("req2_busy_off", 8'(busy1), 8'd0);
        check("req2_mode_kept", 8'(mode1), 8'd2);
        vsync_end();

        // Illegal code: error pulse only.
        strobe(4'd7);
        check("bad_err", 8'(err1), 8'd1);
        check("bad_mode", 8'(mode1), 8'd2);
        check("bad_busy", 8'(busy1), 8'd0);
        tick(1);
        check("bad_err_pulse", 8'(err1), 8'd0);

        // Request equal to the current mode while idle is ignored.
        strobe(4'd2);
        check("same_busy", 8'(busy1), 8'd0);
        check("same_err", 8'(err1), 8'd0);

        // Last request wins.
        do_reset();
        strobe(4'd1);
        tick(2);
        strobe(4'd3);
        vsync_edge();
        check("last_mode", 8'(mode1), 8'd3);
        check("last_mc", 8'(mc1), 8'd1);
        tick(1);
        check("last_mc_pulse", 8'(mc1), 8'd0);
        vsync_end();
        vsync_edge();
        check("last_no_second", 8'(mc1), 8'd0);
        check("last_idle", 8'(busy1), 8'd0);
        vsync_end();

        // Request coinciding with a rise in IDLE commits on the following rise.
        do_reset();
        mode_req = 4'd1;
        mode_req_valid = 1'b1;
        in_vsync = 1'b1;
        tick(1);
        mode_req_valid = 1'b0;
        check("coinc_hold", 8'(mode1), 8'd0);
        check("coinc_busy", 8'(busy1), 8'd1);
        vsync_end();
        vsync_edge();
        check("coinc_commit", 8'(mode1), 8'd1);
        vsync_end();

        // Auto-cycle from mode 3 with BLANK_FRAMES=0, two frames per step.
        do_reset();
        strobe(4'd3);
        vsync_edge();
        check("auto_start", 8'(mode0), 8'd3);
        check("auto_start_idle", 8'(busy0), 8'd0);
        vsync_end();
        auto_cycle_en = 1'b1;
        cycle_frames = 8'd2;
        prev = 4'd3;
        for (int i = 0; i < 5; i++) begin
            vsync_edge();
            check("auto_hold", 8'(mode0), 8'(prev));
            vsync_end();
            vsync_edge();
            check("auto_step", 8'(mode0), 8'(auto_seq[i]));
            check("auto_mc", 8'(mc0), 8'd1);
            check("auto_noblank", 8'(blank0), 8'd0);
            prev = auto_seq[i];
            vsync_end();
        end
        auto_cycle_en = 1'b0;

        // Request during BLANK (BLANK_FRAMES=2) waits for blanking to end.
        do_reset();
        strobe(4'd2);
        vsync_edge();
        check("blk_commit2", 8'(mode2), 8'd2);
        check("blk_on", 8'(blank2), 8'd1);
        vsync_end();
        strobe(4'd1);
        vsync_edge();
        check("blk_f1_mode", 8'(mode2), 8'd2);
        check("blk_f1_blank", 8'(blank2), 8'd1);
        vsync_end();
        vsync_edge();
        check("blk_f2_mode", 8'(mode2), 8'd2);
        check("blk_f2_blank", 8'(blank2), 8'd0);
        check("blk_f2_busy", 8'(busy2), 8'd1);
        vsync_end();
        vsync_edge();
        check("blk_commit1", 8'(mode2), 8'd1);
        check("blk_reassert", 8'(blank2), 8'd1);
        check("blk_mc", 8'(mc2), 8'd1);
        vsync_end();

        // Asynchronous reset while WAIT holds pending 3.
        do_reset();
        strobe(4'd2);
        vsync_edge(); vsync_end();
        vsync_edge(); vsync_end();
        strobe(4'd3);
        check("ar_wait", 8'(busy1), 8'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_mode", 8'(mode1), 8'd0);
        check("ar_busy", 8'(busy1), 8'd0);
        check("ar_blank", 8'(blank1), 8'd0);
        tick(2);
        reset_n = 1'b1;
        tick(2);
        vsync_edge();
        check("ar_no_commit", 8'(mode1), 8'd0);
        check("ar_no_mc", 8'(mc1), 8'd0);
        vsync_end();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
